mult_booth_seq: RTL
===================

MULT_BOOTH_SEQ -- requirements
Module: mult_booth_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, result and adder-port width; only 32 is supported.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ctrl_MULT  in  1  start request, sampled at the rising edge.
REQ-005 SHALL have port data_operandA  in  32  multiplicand M, two's complement.
REQ-006 SHALL have port data_operandB  in  32  multiplier Q, two's complement.
REQ-007 SHALL have port add_A  out  32  drives the CLA's A operand.
REQ-008 SHALL have port add_B  out  32  drives the CLA's B operand: M, or ~M for subtract.
REQ-009 SHALL have port add_cin  out  1  drives the CLA's carry-in (ctrl): 1 on subtract, else 0.
REQ-010 SHALL have port add_en  out  1  drives the CLA's addctrl: 1 when the CLA returns the sum, 0 when it passes add_A through.
REQ-011 SHALL have ports add_S  in  32  and add_ovf  in  1, carrying the CLA sum and the CLA overflow flag.
REQ-012 SHALL have port data_result  out  32  low 32 bits of the product.
REQ-013 SHALL have port data_resultRDY  out  1  one-cycle completion pulse.
REQ-014 SHALL have port data_exception  out  1  product does not fit in 32 bits.
REQ-015 SHALL have port busy  out  1  high while in RUN.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 SHALL, on ctrl_MULT=1 in IDLE or DONE, latch M, load HI=0, LO=Q, q_1=0 and count=0, and enter RUN.
REQ-018 SHALL, in RUN, drive add_A=HI every cycle, and by Booth pair {LO[0],q_1}: 01 -> add_B=M, add_cin=0, add_en=1; 10 -> add_B=~M, add_cin=1, add_en=1; 00/11 -> add_B=M, add_cin=0, add_en=0.
REQ-019 SHALL, at each RUN edge, arithmetic-shift {add_S,LO,q_1} right by one, with shifted-in sign = add_S[31] XOR (add_ovf AND add_en), then increment count.
REQ-020 SHALL go RUN->DONE on the edge at which the 32nd step completes (count==31).
REQ-021 SHALL hold data_resultRDY=1 for exactly the one DONE cycle, i.e. 33 cycles after the start edge; DONE->IDLE absent a start.
REQ-022 SHALL drive data_result=LO and data_exception in DONE, and hold both unchanged in IDLE until the next start edge.
REQ-023 SHALL ignore ctrl_MULT while in RUN, with no effect on state.
REQ-024 SHALL, on ctrl_MULT=1 during DONE, still pulse data_resultRDY that cycle and enter RUN at the next edge, with no idle cycle.
REQ-025 SHALL drive add_en=0 and add_cin=0 outside RUN.

Reset
REQ-026 SHALL, while reset_n=0 (including mid-RUN, where the operation is abandoned), immediately force state IDLE, HI=LO=M=0, q_1=0, count=0 and data_result=0.
REQ-027 SHALL hold data_resultRDY=0, data_exception=0 and busy=0 under reset.
REQ-028 SHALL accept a start on the first edge after reset_n rises.

Configuration
REQ-029 SHALL, with macro MULT_BOOTH_OVERFLOW_EN defined, set data_exception=1 in DONE iff HI != 32 copies of LO[31].
REQ-030 SHALL, without MULT_BOOTH_OVERFLOW_EN, tie data_exception to 0 and omit the comparison logic.

Verification
REQ-031 SHALL cover: A=7, B=6, start -> data_resultRDY exactly 33 cycles later, data_result=0x0000002A, data_exception=0.
REQ-032 SHALL cover: A=-5, B=3 -> data_result=0xFFFFFFF1, data_exception=0.
REQ-033 SHALL cover: A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, data_exception=1 with macro and 0 without.
REQ-034 SHALL cover: A=0x00010000, B=0x00010000 -> data_result=0x00000000, data_exception=1 (macro defined).
REQ-035 SHALL cover: reset_n=0 at RUN cycle 10 -> all outputs 0 at once; then 3x4 -> 0x0000000C after 33 cycles.
REQ-036 SHALL cover: ctrl_MULT pulsed mid-RUN -> ignored, first result correct; ctrl_MULT in the DONE cycle -> back-to-back result 33 cycles later.

Source files
------------

// File: rtl/mult_booth_seq.sv
// mult_booth_seq -- sequential radix-2 Booth multiplier, 32x32 -> low 32 bits.
//
// The adder is external: this block drives a carry-lookahead adder through
// add_A/add_B/add_cin/add_en and takes back its sum (add_S) and signed
// overflow flag (add_ovf). One Booth step is retired per clock; a start
// edge is followed by 32 RUN cycles and a single DONE cycle that pulses
// data_resultRDY.
//
// Ports
//   clock, reset_n          : clock, async active-low reset
//   ctrl_MULT               : start request (accepted in IDLE or DONE)
//   data_operandA/B         : multiplicand M / multiplier Q (two's complement)
//   add_A, add_B, add_cin   : adder operands / carry-in
//   add_en                  : 1 = adder returns the sum, 0 = passes add_A
//   add_S, add_ovf          : adder sum and overflow
//   data_result             : low 32 bits of the product, held until the
//                             next completion
//   data_resultRDY          : one-cycle completion pulse
//   data_exception          : product does not fit in 32 bits
//   busy                    : high while in RUN
//
// Build option: define MULT_BOOTH_OVERFLOW_EN to enable data_exception;
// without it data_exception is tied to 0.

module mult_booth_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] add_A,
  output logic [WIDTH-1:0] add_B,
  output logic             add_cin,
  output logic             add_en,
  input  logic [WIDTH-1:0] add_S,
  input  logic             add_ovf,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             data_exception,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] hi, lo, m;
  logic             q_1;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] result_q;
  logic             rdy_q, busy_q;

  logic             run;
  logic [1:0]       booth;
  logic             sub, add;
  logic             shift_sign;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;

  assign run   = (state == RUN);
  assign booth = {lo[0], q_1};
  assign sub   = run && (booth == 2'b10);
  assign add   = run && (booth == 2'b01);

  assign add_A   = hi;
  assign add_B   = sub ? ~m : m;
  assign add_cin = sub;
  assign add_en  = sub | add;

  // The CLA sum is only 32 bits; when it overflows, its MSB is the wrong
  // sign, so the true sign of the 33-bit sum is the inverted MSB.
  assign shift_sign = add_S[WIDTH-1] ^ (add_ovf & add_en);
  assign hi_nxt     = {shift_sign, add_S[WIDTH-1:1]};
  assign lo_nxt     = {add_S[0], lo[WIDTH-1:1]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      hi       <= '0;
      lo       <= '0;
      m        <= '0;
      q_1      <= 1'b0;
      count    <= '0;
      result_q <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          hi    <= hi_nxt;
          lo    <= lo_nxt;
          q_1   <= lo[0];
          count <= count + 1'b1;
          if (count == CW'(WIDTH-1)) begin
            state    <= DONE;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b1;
            result_q <= lo_nxt;
          end
        end
        default: begin  // IDLE and DONE both accept a start
          rdy_q <= 1'b0;
          if (ctrl_MULT) begin
            state  <= RUN;
            busy_q <= 1'b1;
            m      <= data_operandA;
            hi     <= '0;
            lo     <= data_operandB;
            q_1    <= 1'b0;
            count  <= '0;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef MULT_BOOTH_OVERFLOW_EN
  // Product fits in 32 bits iff the high word is pure sign extension of
  // the low word; evaluated on the final shifted values at the last step.
  logic exc_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      exc_q <= 1'b0;
    else if (run && count == CW'(WIDTH-1))
      exc_q <= (hi_nxt != {WIDTH{lo_nxt[WIDTH-1]}});
  end
  assign data_exception = exc_q;
`else
  assign data_exception = 1'b0;
`endif

  assign data_result    = result_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule
